// File: rtl/c1541_sd_pkg.sv
// Shared definitions for the 1541 disk stage and its SD-card sector bridge.
package c1541_sd_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int CNT_W        = $clog2(SECTOR_BYTES) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RX,
    TX_FETCH,
    TX,
    FINISH
  } state_t;

endpackage

// File: rtl/c1541_sd_bridge_if.sv
// Card-side command and byte-stream bus between the sector bridge and the SD controller.
interface c1541_sd_bridge_if;

  logic [31:0] card_lba;
  logic        card_rd;
  logic        card_wr;
  logic        card_busy;
  logic        card_done;
  logic        card_err;
  logic        card_rx_valid;
  logic [7:0]  card_rx_data;
  logic        card_tx_valid;
  logic        card_tx_ready;
  logic [7:0]  card_tx_data;

  modport master (
    output card_lba, card_rd, card_wr, card_tx_valid, card_tx_data,
    input  card_busy, card_done, card_err, card_rx_valid, card_rx_data, card_tx_ready
  );

  modport slave (
    input  card_lba, card_rd, card_wr, card_tx_valid, card_tx_data,
    output card_busy, card_done, card_err, card_rx_valid, card_rx_data, card_tx_ready
  );

endinterface

// File: rtl/c1541_sd_bridge.sv
// Moves one 512-byte image sector between the 1541 track buffer and the SD card,
// with bounds checking, a card-event watchdog and a sticky error flag.
module c1541_sd_bridge
  import c1541_sd_pkg::*;
#(
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 2**22
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             img_base,
  input  logic [31:0]             img_size,
  input  logic                    mounted,
  input  logic [31:0]             sd_lba,
  input  logic                    sd_rd,
  input  logic                    sd_wr,
  output logic                    sd_ack,
  output logic [8:0]              sd_buff_addr,
  output logic [7:0]              sd_buff_dout,
  output logic                    sd_buff_wr,
  input  logic [7:0]              sd_buff_din,
  output logic                    err,
  c1541_sd_bridge_if.master       card
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_wdog;
  logic [1:0]       r_lat;
  logic             r_isWr;
  logic             r_reject;

  logic w_cntFull;
  logic w_lastTx;
  logic w_timeout;
  logic w_inRange;

  assign w_cntFull = (r_cnt == CNT_W'(SECTOR_BYTES));
  assign w_lastTx  = (r_cnt == CNT_W'(SECTOR_BYTES - 1));
  assign w_timeout = (r_wdog == 32'(TIMEOUT_CYC - 1));
  assign w_inRange = mounted && (sd_lba < img_size);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state            <= IDLE;
      r_cnt              <= '0;
      r_wdog             <= '0;
      r_lat              <= '0;
      r_isWr             <= 1'b0;
      r_reject           <= 1'b0;
      sd_ack             <= 1'b0;
      sd_buff_addr       <= '0;
      sd_buff_dout       <= '0;
      sd_buff_wr         <= 1'b0;
      err                <= 1'b0;
      card.card_lba      <= '0;
      card.card_rd       <= 1'b0;
      card.card_wr       <= 1'b0;
      card.card_tx_valid <= 1'b0;
      card.card_tx_data  <= '0;
    end else begin
      sd_buff_wr <= 1'b0;
      case (r_state)
        IDLE: begin
          if ((sd_rd || sd_wr) && !sd_ack) begin
            sd_ack   <= 1'b1;
            err      <= !w_inRange;
            r_reject <= !w_inRange;
            r_isWr   <= !sd_rd;
            r_cnt    <= '0;
            r_wdog   <= '0;
            r_lat    <= '0;
            r_state  <= ISSUE;
            if (w_inRange) begin
              card.card_lba <= img_base + sd_lba;
              card.card_rd  <= sd_rd;
              card.card_wr  <= !sd_rd;
            end
          end
        end

        ISSUE: begin
          // A rejected request reuses the watchdog to hold sd_ack for a second cycle.
          if (r_reject) begin
            if (r_wdog == '0) begin
              r_wdog <= 32'd1;
            end else begin
              sd_ack  <= 1'b0;
              r_state <= FINISH;
            end
          end else if (card.card_done) begin
            card.card_rd <= 1'b0;
            card.card_wr <= 1'b0;
            err          <= card.card_err | !w_cntFull;
            sd_ack       <= 1'b0;
            r_state      <= FINISH;
          end else if (card.card_busy) begin
            card.card_rd <= 1'b0;
            card.card_wr <= 1'b0;
            r_wdog       <= '0;
            sd_buff_addr <= '0;
            r_lat        <= '0;
            r_state      <= r_isWr ? TX_FETCH : RX;
          end else if (w_timeout) begin
            card.card_rd <= 1'b0;
            card.card_wr <= 1'b0;
            err          <= 1'b1;
            sd_ack       <= 1'b0;
            r_state      <= FINISH;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end

        RX: begin
          if (card.card_done) begin
            err     <= card.card_err | !w_cntFull;
            sd_ack  <= 1'b0;
            r_state <= FINISH;
          end else if (card.card_rx_valid) begin
            r_wdog <= '0;
            if (!w_cntFull) begin
              sd_buff_dout <= card.card_rx_data;
              sd_buff_addr <= r_cnt[8:0];
              sd_buff_wr   <= 1'b1;
              r_cnt        <= r_cnt + CNT_W'(1);
            end
          end else if (w_timeout) begin
            err     <= 1'b1;
            sd_ack  <= 1'b0;
            r_state <= FINISH;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end

        TX_FETCH: begin
          if (card.card_done) begin
            err     <= card.card_err | !w_cntFull;
            sd_ack  <= 1'b0;
            r_state <= FINISH;
          end else if (w_timeout) begin
            err     <= 1'b1;
            sd_ack  <= 1'b0;
            r_state <= FINISH;
          end else begin
            r_wdog <= r_wdog + 32'd1;
            if (r_lat == 2'(RD_LAT - 1)) begin
              card.card_tx_data  <= sd_buff_din;
              card.card_tx_valid <= 1'b1;
              r_state            <= TX;
            end else begin
              r_lat <= r_lat + 2'd1;
            end
          end
        end

        TX: begin
          // Once all 512 bytes are sent we stay here with valid low until card_done.
          if (card.card_done) begin
            card.card_tx_valid <= 1'b0;
            err                <= card.card_err | !w_cntFull;
            sd_ack             <= 1'b0;
            r_state            <= FINISH;
          end else if (card.card_tx_valid && card.card_tx_ready) begin
            r_wdog             <= '0;
            card.card_tx_valid <= 1'b0;
            r_cnt              <= r_cnt + CNT_W'(1);
            if (!w_lastTx) begin
              sd_buff_addr <= r_cnt[8:0] + 9'd1;
              r_lat        <= '0;
              r_state      <= TX_FETCH;
            end
          end else if (w_timeout) begin
            card.card_tx_valid <= 1'b0;
            err                <= 1'b1;
            sd_ack             <= 1'b0;
            r_state            <= FINISH;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end

        FINISH: r_state <= IDLE;

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c1541_sd_bridge.sv
// Directed-plus-random bench for c1541_sd_bridge with a card model and track-buffer model.
module tb_c1541_sd_bridge;

  localparam int TMO    = 1000;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] img_base;
  logic [31:0] img_size;
  logic        mounted;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        err;

  c1541_sd_bridge_if card ();

  c1541_sd_bridge #(.RD_LAT(RD_LAT), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .img_base     (img_base),
    .img_size     (img_size),
    .mounted      (mounted),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .err          (err),
    .card         (card.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] tbMem [512];
  logic [7:0] rxBytes [600];
  logic [7:0] dinReg;

  // Track buffer with two-cycle read latency: one register stage after the address.
  always @(posedge clk) dinReg <= tbMem[sd_buff_addr];
  assign sd_buff_din = dinReg;

  logic [8:0] wrAddrQ [$];
  logic [7:0] wrDataQ [$];
  logic [7:0] txQ [$];
  int ackCycles = 0;
  int rdCycles  = 0;

  always @(negedge clk) begin
    if (sd_buff_wr) begin
      wrAddrQ.push_back(sd_buff_addr);
      wrDataQ.push_back(sd_buff_dout);
    end
    if (card.card_tx_valid && card.card_tx_ready) txQ.push_back(card.card_tx_data);
    if (sd_ack) ackCycles++;
    if (card.card_rd) rdCycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitAck(input logic level, input int bound, input string tag);
    for (int k = 0; k < bound && sd_ack !== level; k++) tick();
    check(tag, 64'(sd_ack), 64'(level));
  endtask

  task automatic cardDone(input bit e);
    card.card_done = 1'b1;
    card.card_err  = e;
    tick();
    card.card_done = 1'b0;
    card.card_err  = 1'b0;
    card.card_busy = 1'b0;
  endtask

  task automatic applyRead(input logic [31:0] lba, input int nBytes, input bit cardErr, input string tag);
    int wq0, nExp, nGot, bad;
    logic [31:0] expLba;
    expLba = img_base + lba;
    wq0 = wrAddrQ.size();
    sd_lba = lba;
    sd_rd  = 1'b1;
    waitAck(1'b1, 10, {tag, "_ackrise"});
    sd_rd  = 1'b0;
    sd_lba = $urandom;
    check({tag, "_errclr"}, 64'(err), 64'(0));
    check({tag, "_cardrd"}, 64'({card.card_rd, card.card_wr}), 64'(2'b10));
    check({tag, "_lba"}, 64'(card.card_lba), 64'(expLba));
    repeat ($urandom_range(0, 3)) tick();
    card.card_busy = 1'b1;
    tick();
    check({tag, "_rddrop"}, 64'(card.card_rd), 64'(0));
    for (int i = 0; i < nBytes; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      card.card_rx_valid = 1'b1;
      card.card_rx_data  = rxBytes[i];
      tick();
      card.card_rx_valid = 1'b0;
    end
    tick();
    cardDone(cardErr);
    waitAck(1'b0, 5, {tag, "_ackfall"});
    nExp = (nBytes < 512) ? nBytes : 512;
    nGot = wrAddrQ.size() - wq0;
    check({tag, "_nstrobe"}, 64'(nGot), 64'(nExp));
    bad = 0;
    for (int i = 0; i < nGot && i < nExp; i++)
      if (wrAddrQ[wq0 + i] !== 9'(i) || wrDataQ[wq0 + i] !== rxBytes[i]) bad++;
    check({tag, "_data"}, 64'(bad), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(cardErr || nBytes < 512));
  endtask

  task automatic applyWrite(input logic [31:0] lba, input string tag);
    int tq0, nGot, bad;
    logic [7:0] expTx [512];
    for (int i = 0; i < 512; i++) expTx[i] = tbMem[i];
    tq0 = txQ.size();
    sd_lba = lba;
    sd_wr  = 1'b1;
    waitAck(1'b1, 10, {tag, "_ackrise"});
    sd_wr = 1'b0;
    check({tag, "_cardwr"}, 64'({card.card_rd, card.card_wr}), 64'(2'b01));
    check({tag, "_lba"}, 64'(card.card_lba), 64'(img_base + lba));
    repeat ($urandom_range(0, 3)) tick();
    card.card_busy = 1'b1;
    tick();
    for (int k = 0; k < 20000 && (txQ.size() - tq0) < 512; k++) begin
      card.card_tx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    card.card_tx_ready = 1'b0;
    nGot = txQ.size() - tq0;
    check({tag, "_nbytes"}, 64'(nGot), 64'(512));
    bad = 0;
    for (int i = 0; i < nGot && i < 512; i++)
      if (txQ[tq0 + i] !== expTx[i]) bad++;
    check({tag, "_data"}, 64'(bad), 64'(0));
    repeat (4) tick();
    check({tag, "_novalid"}, 64'(card.card_tx_valid), 64'(0));
    cardDone(1'b0);
    waitAck(1'b0, 5, {tag, "_ackfall"});
    check({tag, "_err"}, 64'(err), 64'(0));
  endtask

  task automatic applyReject(input logic [31:0] lba, input string tag);
    int ack0, rd0, wq0;
    ack0 = ackCycles;
    rd0  = rdCycles;
    wq0  = wrAddrQ.size();
    sd_lba = lba;
    sd_rd  = 1'b1;
    waitAck(1'b1, 10, {tag, "_ackrise"});
    sd_rd = 1'b0;
    waitAck(1'b0, 10, {tag, "_ackfall"});
    tick();
    check({tag, "_ackcyc"}, 64'(ackCycles - ack0), 64'(2));
    check({tag, "_nocardrd"}, 64'(rdCycles - rd0), 64'(0));
    check({tag, "_nostrobe"}, 64'(wrAddrQ.size() - wq0), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(1));
  endtask

  task automatic checkOutput(input string tag);
    check(tag, 64'({sd_ack, sd_buff_wr, card.card_rd, card.card_wr, card.card_tx_valid, err,
                    sd_buff_addr, sd_buff_dout, card.card_tx_data, card.card_lba}), 64'(0));
  endtask

  initial begin
    int ack0, wq0;
    reset_n = 1'b0;
    img_base = 32'h800;
    img_size = 32'd683;
    mounted  = 1'b1;
    sd_lba   = '0;
    sd_rd    = 1'b0;
    sd_wr    = 1'b0;
    card.card_busy     = 1'b0;
    card.card_done     = 1'b0;
    card.card_err      = 1'b0;
    card.card_rx_valid = 1'b0;
    card.card_rx_data  = '0;
    card.card_tx_ready = 1'b0;
    for (int i = 0; i < 512; i++) tbMem[i] = '0;
    repeat (3) tick();
    checkOutput("reset_state");
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 600; i++) rxBytes[i] = 8'(i);
    applyRead(32'd5, 512, 1'b0, "rd_basic");

    for (int r = 0; r < 2; r++) begin
      img_base = $urandom;
      for (int i = 0; i < 600; i++) rxBytes[i] = 8'($urandom);
      applyRead(32'($urandom_range(0, 682)), 512, 1'b0, $sformatf("rd_rand%0d", r));
    end
    img_base = 32'h800;

    applyReject(32'd683, "bound_683");
    applyRead(32'd682, 512, 1'b0, "bound_682");

    mounted = 1'b0;
    applyReject(32'd0, "unmounted");
    mounted = 1'b1;

    for (int i = 0; i < 600; i++) rxBytes[i] = 8'($urandom);
    applyRead(32'd7, 300, 1'b0, "rd_short");
    applyRead(32'd8, 512, 1'b0, "rd_after_short");
    applyRead(32'd9, 512, 1'b1, "rd_cardErr");
    applyRead(32'd10, 520, 1'b0, "rd_overflow");

    for (int i = 0; i < 512; i++) tbMem[i] = ~8'(i);
    applyWrite(32'd3, "wr_inv");
    for (int i = 0; i < 512; i++) tbMem[i] = 8'($urandom);
    applyWrite(32'd600, "wr_rand");

    ack0 = ackCycles;
    sd_lba = 32'd20;
    sd_rd  = 1'b1;
    waitAck(1'b1, 10, "tmo_ackrise");
    sd_rd = 1'b0;
    waitAck(1'b0, TMO + 20, "tmo_ackfall");
    check("tmo_cardrd", 64'(card.card_rd), 64'(0));
    check("tmo_err", 64'(err), 64'(1));
    tick();
    check("tmo_ackcyc", 64'(ackCycles - ack0), 64'(TMO));

    for (int i = 0; i < 600; i++) rxBytes[i] = 8'($urandom);
    sd_lba = 32'd30;
    sd_rd  = 1'b1;
    sd_wr  = 1'b1;
    waitAck(1'b1, 10, "both_ackrise");
    check("both_isread", 64'({card.card_rd, card.card_wr}), 64'(2'b10));
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    card.card_busy = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      card.card_rx_valid = 1'b1;
      card.card_rx_data  = rxBytes[i];
      tick();
    end
    card.card_rx_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    checkOutput("abort_reset");
    reset_n = 1'b1;
    card.card_busy = 1'b0;
    wq0 = wrAddrQ.size();
    for (int i = 0; i < 5; i++) begin
      card.card_rx_valid = 1'b1;
      card.card_rx_data  = 8'($urandom);
      tick();
    end
    card.card_rx_valid = 1'b0;
    cardDone(1'b0);
    tick();
    check("abort_stray", 64'(wrAddrQ.size() - wq0), 64'(0));
    check("abort_idle", 64'({sd_ack, err}), 64'(0));
    applyRead(32'd31, 512, 1'b0, "rd_after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c1541_sd_bridge.md
C1541_SD_BRIDGE -- requirements
Module: c1541_sd_bridge

Interface
REQ-001 Parameter RD_LAT, default 1: cycles from sd_buff_addr change to valid sd_buff_din (track-buffer read latency), range 1..3.
REQ-002 Parameter TIMEOUT_CYC, default 2**22: maximum cycles to wait for any card-side event.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 img_base  in  32  card sector holding image sector 0.
REQ-006 img_size  in  32  image length in sectors.
REQ-007 mounted  in  1  image valid.
REQ-008 sd_lba  in  32  image-relative sector requested by the disk stage.
REQ-009 sd_rd / sd_wr  in  1 each  level requests, held until sd_ack seen.
REQ-010 sd_ack  out  1  high for the whole transfer; its falling edge marks completion.
REQ-011 sd_buff_addr  out  9  byte index within the sector.
REQ-012 sd_buff_dout  out  8  read byte to the disk stage.
REQ-013 sd_buff_wr  out  1  one-cycle write strobe for sd_buff_dout.
REQ-014 sd_buff_din  in  8  write byte from the disk stage.
REQ-015 card_lba  out  32  absolute card sector.
REQ-016 card_rd / card_wr  out  1 each  card command requests.
REQ-017 card_busy  in  1  card accepted the command / transfer in progress.
REQ-018 card_done  in  1  one-cycle end-of-command pulse.
REQ-019 card_err  in  1  valid with card_done; command failed.
REQ-020 card_rx_valid  in  1; card_rx_data  in  8: read byte stream.
REQ-021 card_tx_valid  out  1; card_tx_ready  in  1; card_tx_data  out  8: write byte stream, byte moves when valid&ready.
REQ-022 err  out  1  sticky failure flag, cleared at the start of the next request.

Function
REQ-023 FSM states: IDLE, ISSUE, RX, TX_FETCH, TX, FINISH.
REQ-024 In IDLE, sd_rd or sd_wr high and sd_ack low starts a request; sd_rd wins if both are high.
REQ-025 Bounds check: !mounted or sd_lba >= img_size (unsigned) -> no card command, err=1, sd_ack high exactly 2 cycles, no sd_buff_wr.
REQ-026 card_lba = img_base + sd_lba, 32-bit modulo, registered at request start, stable until FINISH.
REQ-027 ISSUE: sd_ack=1 from the first ISSUE cycle; card_rd/card_wr held high until card_busy is sampled high, then dropped.
REQ-028 RX: each card_rx_valid yields sd_buff_dout=card_rx_data and sd_buff_wr=1 on the next cycle, with sd_buff_addr = byte count; count increments after.
REQ-029 RX: bytes beyond 512 are ignored; card_done with count != 512, or card_err, -> err=1.
REQ-030 TX_FETCH: present sd_buff_addr, wait RD_LAT cycles, latch sd_buff_din into the hold register, assert card_tx_valid.
REQ-031 TX: on valid&ready, increment address and return to TX_FETCH; card_tx_valid is low during the fetch; after byte 511, wait for card_done.
REQ-032 FINISH: sd_ack drops for 1 cycle, then IDLE; a new request is not accepted in the FINISH cycle.
REQ-033 Watchdog: counter resets on every card event (busy rise, rx byte, tx byte, done); reaching TIMEOUT_CYC -> err=1, card_rd/card_wr low, FINISH.
REQ-034 card_done arriving during ISSUE (busy never seen) is treated as completion: err follows card_err, plus err if RX count != 512.
REQ-035 sd_lba, sd_rd and sd_wr changes during a transfer are ignored.

Reset
REQ-036 reset_n low at a clock edge -> IDLE; sd_ack, sd_buff_wr, card_rd, card_wr, card_tx_valid, err = 0; sd_buff_addr, sd_buff_dout, card_tx_data = 0; card_lba = 0; counters cleared.
REQ-037 Reset mid-transfer aborts immediately; card-side bytes arriving after reset is released are ignored until a new request starts.

Structure
REQ-038 Package c1541_sd_pkg holds the FSM state enum, SECTOR_BYTES=512 and the byte-count width; the 1541 disk stage imports the same package.
REQ-039 No sub-module; byte counter, watchdog and hold register live in this module.

Verification
REQ-040 img_base=0x800, sd_lba=5, sd_rd, model supplies 512 bytes i&0xFF -> card_lba=0x805, 512 sd_buff_wr strobes, addr 0..511 with data = addr[7:0], sd_ack falls, err=0.
REQ-041 RD_LAT=2, sd_wr, buffer holds ~i -> 512 card bytes equal ~i in order, including random card_tx_ready stalls; err=0.
REQ-042 img_size=683, sd_lba=683 -> no card_rd, sd_ack high 2 cycles, err=1; sd_lba=682 accepted.
REQ-043 Card delivers 300 bytes, then card_done -> err=1, sd_ack falls; next valid read clears err.
REQ-044 Card never raises card_busy -> at TIMEOUT_CYC, card_rd=0, sd_ack falls, err=1.
REQ-045 sd_rd and sd_wr high together -> read performed; reset_n low at RX byte 100 -> all outputs 0 next cycle, later request completes normally.
